// File: rtl/merge_tree_selftest_pkg.sv
// Shared definitions for the MERGE_TREE self-test: FSM states, error codes,
// sentinel key and stall-injection LFSR constants.
package merge_tree_selftest_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_CONFIG   = 2'd3;

    // Sliced down to KEYW at the point of use.
    localparam logic [63:0] SENTINEL_KEY = '1;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/merge_tree_selftest_lane.sv
// One input-lane record generator: key counter, per-lane record budget and
// sentinel switch. MERGE_TREE_SELFTEST_STALL_INJECT_EN adds an LFSR gap source.
module merge_tree_selftest_lane
    import merge_tree_selftest_pkg::*;
#(
    parameter int E_LOG = 2,
    parameter int KEYW  = 32,
    parameter int PAYW  = 32,
    parameter int DATW  = PAYW + KEYW,
    parameter int LANE  = 0
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [31:0]     num_beats,
    output logic            gap,
    output logic [DATW-1:0] rec
);

    localparam int WAYS = 1 << E_LOG;

    logic            armed;
    logic [31:0]     sent;
    logic [KEYW-1:0] key;

    always_ff @(posedge CLK) begin
        if (rst) begin
            armed <= 1'b0;
            sent  <= '0;
            key   <= '0;
        end else if (clr) begin
            armed <= 1'b1;
            sent  <= '0;
            key   <= KEYW'(WAYS - LANE);
        end else if (en && (sent < num_beats)) begin
            sent <= sent + 32'd1;
            key  <= key + KEYW'(WAYS);
        end
    end

    // Key occupies the low KEYW bits, so the increment can never reach the payload.
    assign rec = !armed              ? '0 :
                 (sent >= num_beats) ? DATW'(SENTINEL_KEY[KEYW-1:0]) :
                                       (DATW'(key) | (DATW'(LANE + 1) << KEYW));

`ifdef MERGE_TREE_SELFTEST_STALL_INJECT_EN
    logic [15:0] lfsr;

    always_ff @(posedge CLK) begin
        if (rst || clr)
            lfsr <= LFSR_SEED ^ 16'(LANE);
        else if (armed)
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end

    assign gap = (lfsr[1:0] == 2'b00);
`else
    assign gap = 1'b0;
`endif

endmodule

// File: rtl/merge_tree_selftest.sv
// Synthesisable stimulus generator and output checker for MERGE_TREE.
// Optional random lane gaps: define MERGE_TREE_SELFTEST_STALL_INJECT_EN.
module merge_tree_selftest
    import merge_tree_selftest_pkg::*;
#(
    parameter int E_LOG   = 2,
    parameter int KEYW    = 32,
    parameter int PAYW    = 32,
    parameter int DATW    = PAYW + KEYW,
    parameter int TIMEOUT = 1024
) (
    input  logic                        CLK,
    input  logic                        rst,
    input  logic                        start,
    input  logic [31:0]                 num_beats,
    output logic [DATW*(1<<E_LOG)-1:0]  tree_din,
    output logic [(1<<E_LOG)-1:0]       tree_dinen,
    input  logic [(1<<E_LOG)-1:0]       tree_ful,
    input  logic [DATW*(1<<E_LOG)-1:0]  tree_dot,
    input  logic                        tree_doten,
    output logic                        busy,
    output logic                        done,
    output logic                        fail,
    output logic [1:0]                  err_code,
    output logic [31:0]                 err_beat,
    output logic [31:0]                 beat_cnt
);

    localparam int WAYS = 1 << E_LOG;
    localparam logic [95:0] KEY_LIM = (96'd1 << KEYW) - 96'd1;

    state_t          state, state_nxt;
    logic [31:0]     nb_reg;
    logic [WAYS-1:0] stall;
    logic [WAYS-1:0] gap;
    logic [KEYW-1:0] base_key;
    logic [31:0]     wdog;
    logic            accept, cfg_bad, mismatch, lane_clr;

    always_comb begin
        accept   = start && (state != ST_RUN);
        cfg_bad  = (num_beats == 32'd0) || ((96'(num_beats) << E_LOG) >= KEY_LIM);
        // A beat arriving after the budget is spent is an error even if it looks right.
        mismatch = (beat_cnt >= nb_reg);
        for (int j = 0; j < WAYS; j++) begin
            if (tree_dot[DATW*j +: DATW] !=
                (DATW'(base_key + KEYW'(j + 1)) | (DATW'(WAYS - j) << KEYW)))
                mismatch = 1'b1;
        end
        state_nxt = state;
        if (accept) begin
            state_nxt = cfg_bad ? ST_FAIL : ST_RUN;
        end else if (state == ST_RUN) begin
            if (tree_doten) begin
                if (mismatch)
                    state_nxt = ST_FAIL;
                else if (beat_cnt + 32'd1 == nb_reg)
                    state_nxt = ST_DONE;
            end else if (wdog + 32'd1 == 32'(TIMEOUT)) begin
                state_nxt = ST_FAIL;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state    <= ST_IDLE;
            nb_reg   <= '0;
            stall    <= '0;
            base_key <= '0;
            wdog     <= '0;
            beat_cnt <= '0;
            err_code <= ERR_NONE;
            err_beat <= '0;
        end else begin
            state <= state_nxt;
            stall <= tree_ful;
            if (accept) begin
                nb_reg   <= num_beats;
                base_key <= '0;
                wdog     <= '0;
                beat_cnt <= '0;
                err_beat <= '0;
                err_code <= cfg_bad ? ERR_CONFIG : ERR_NONE;
            end else if (state == ST_RUN) begin
                if (tree_doten) begin
                    wdog     <= '0;
                    beat_cnt <= beat_cnt + 32'd1;
                    base_key <= base_key + KEYW'(WAYS);
                    if (mismatch) begin
                        err_code <= ERR_MISMATCH;
                        err_beat <= beat_cnt;
                    end
                end else begin
                    wdog <= wdog + 32'd1;
                    if (wdog + 32'd1 == 32'(TIMEOUT))
                        err_code <= ERR_TIMEOUT;
                end
            end
        end
    end

    // Enables follow the full flags one cycle late, matching the coupler timing.
    assign tree_dinen = (state == ST_RUN) ? (~stall & ~gap) : '0;
    assign lane_clr   = accept && !cfg_bad;
    assign busy       = (state == ST_RUN);
    assign done       = (state == ST_DONE);
    assign fail       = (state == ST_FAIL);

    for (genvar i = 0; i < WAYS; i++) begin : g_lane
        merge_tree_selftest_lane #(
            .E_LOG (E_LOG),
            .KEYW  (KEYW),
            .PAYW  (PAYW),
            .DATW  (DATW),
            .LANE  (i)
        ) u_lane (
            .CLK       (CLK),
            .rst       (rst),
            .clr       (lane_clr),
            .en        (tree_dinen[i]),
            .num_beats (nb_reg),
            .gap       (gap[i]),
            .rec       (tree_din[DATW*i +: DATW])
        );
    end

endmodule

// File: tb/tb_merge_tree_selftest.sv
// Bench for merge_tree_selftest with a behavioural merge-tree stand-in and a
// per-cycle model of lane records, enables and beat count.
`timescale 1ns/1ps
module tb_merge_tree_selftest;

    localparam int E_LOG   = 2;
    localparam int WAYS    = 4;
    localparam int KEYW    = 32;
    localparam int PAYW    = 32;
    localparam int DATW    = 64;
    localparam int TIMEOUT = 16;
    localparam logic [63:0] SENT_REC = 64'h00000000_FFFFFFFF;

    logic                   CLK = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [31:0]            num_beats = '0;
    logic [DATW*WAYS-1:0]   tree_din;
    logic [WAYS-1:0]        tree_dinen;
    logic [WAYS-1:0]        tree_ful = '0;
    logic [DATW*WAYS-1:0]   tree_dot = '0;
    logic                   tree_doten = 1'b0;
    logic                   busy, done, fail;
    logic [1:0]             err_code;
    logic [31:0]            err_beat, beat_cnt;

    int total = 0;
    int bad   = 0;

    // 0: honest merge, 1: corrupt lane 1 key of beat 7, 2: never emit
    int tree_mode = 0;
    int cur_n     = 0;

    int              m_beats = 0;
    int              sent [WAYS];
    logic            prev_busy = 1'b0;
    logic [WAYS-1:0] ful_prev = '0;
    logic [31:0]     pool [logic [31:0]];
    logic [31:0]     next_key = 32'd1;
    int              tbeat = 0;
    logic [63:0]     want_rec;
    logic            all_in;

    logic [63:0] start_exp [WAYS] = '{64'h00000001_00000004, 64'h00000002_00000003,
                                      64'h00000003_00000002, 64'h00000004_00000001};
    logic [63:0] beat0_exp [WAYS] = '{64'h00000004_00000001, 64'h00000003_00000002,
                                      64'h00000002_00000003, 64'h00000001_00000004};

    merge_tree_selftest #(
        .E_LOG   (E_LOG),
        .KEYW    (KEYW),
        .PAYW    (PAYW),
        .DATW    (DATW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .start      (start),
        .num_beats  (num_beats),
        .tree_din   (tree_din),
        .tree_dinen (tree_dinen),
        .tree_ful   (tree_ful),
        .tree_dot   (tree_dot),
        .tree_doten (tree_doten),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .err_code   (err_code),
        .err_beat   (err_beat),
        .beat_cnt   (beat_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Model and merge-tree stand-in, evaluated mid-cycle while everything is stable.
    always @(negedge CLK) begin
        if (rst) begin
            prev_busy  = 1'b0;
            tree_doten = 1'b0;
            tree_dot   = '0;
            pool.delete();
            ful_prev   = tree_ful;
        end else begin
            if (tree_doten && prev_busy)
                m_beats++;
            if (busy && !prev_busy) begin
                m_beats = 0;
                foreach (sent[i]) sent[i] = 0;
                pool.delete();
                next_key = 32'd1;
                tbeat    = 0;
            end
            if (busy || prev_busy)
                check("beat_cnt", 64'(beat_cnt), 64'(m_beats));
            if (busy) begin
                for (int i = 0; i < WAYS; i++) begin
                    check($sformatf("dinen%0d", i), 64'(tree_dinen[i]), 64'(!ful_prev[i]));
                    want_rec = (sent[i] < cur_n) ?
                               {32'(i + 1), 32'(WAYS - i + WAYS * sent[i])} : SENT_REC;
                    check($sformatf("din%0d", i), tree_din[DATW*i +: DATW], want_rec);
                    if (tree_dinen[i])
                        sent[i]++;
                end
            end
            tree_doten = 1'b0;
            tree_dot   = '0;
            all_in = 1'b1;
            for (int j = 0; j < WAYS; j++)
                if (!pool.exists(next_key + 32'(j)))
                    all_in = 1'b0;
            if (tree_mode != 2 && all_in) begin
                for (int j = 0; j < WAYS; j++) begin
                    tree_dot[DATW*j +: DATW] = {pool[next_key + 32'(j)], next_key + 32'(j)};
                    pool.delete(next_key + 32'(j));
                end
                if (tree_mode == 1 && tbeat == 7)
                    tree_dot[DATW +: KEYW] = tree_dot[DATW +: KEYW] ^ 32'h10;
                tree_doten = 1'b1;
                tbeat++;
                next_key = next_key + 32'(WAYS);
            end
            if (busy) begin
                for (int i = 0; i < WAYS; i++)
                    if (tree_dinen[i] && tree_din[DATW*i +: KEYW] != 32'hFFFFFFFF)
                        pool[tree_din[DATW*i +: KEYW]] = tree_din[DATW*i + KEYW +: PAYW];
            end
            ful_prev  = tree_ful;
            prev_busy = busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_start(input int n);
        cur_n = n;
        @(posedge CLK);
        #1;
        num_beats = 32'(n);
        start     = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        check("run_ends", 64'(busy), 64'd0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_fail"}, 64'(fail), 64'd0);
        check({tag, "_err_code"}, 64'(err_code), 64'd0);
        check({tag, "_err_beat"}, 64'(err_beat), 64'd0);
        check({tag, "_beat_cnt"}, 64'(beat_cnt), 64'd0);
        check({tag, "_dinen"}, 64'(tree_dinen), 64'd0);
        check({tag, "_din_zero"}, 64'(tree_din != '0), 64'd0);
    endtask

    initial begin
        int n;
        int lows;
        logic [63:0] k_first;

        tick(3);
        check_cleared("reset");
        rst = 1'b0;
        tick(1);

        // Plain run of 50 beats
        do_start(50);
        check("start_dinen", 64'(tree_dinen), 64'hF);
        for (int i = 0; i < WAYS; i++)
            check($sformatf("start_lane%0d", i), tree_din[DATW*i +: DATW], start_exp[i]);
        n = 0;
        while (!tree_doten && n < 20) begin
            tick(1);
            n++;
        end
        for (int j = 0; j < WAYS; j++)
            check($sformatf("beat0_lane%0d", j), tree_dot[DATW*j +: DATW], beat0_exp[j]);
        wait_idle(300);
        check("t1_done", 64'(done), 64'd1);
        check("t1_fail", 64'(fail), 64'd0);
        check("t1_beat_cnt", 64'(beat_cnt), 64'd50);
        check("t1_err_code", 64'(err_code), 64'd0);

        // Lane 2 held full for 10 cycles mid-run
        do_start(50);
        tick(8);
        tree_ful[2] = 1'b1;
        lows = 0;
        k_first = '0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (!tree_dinen[2]) lows++;
            if (k == 1) k_first = tree_din[DATW*2 +: DATW];
            if (k == 10) begin
                check("stall_key_hold", tree_din[DATW*2 +: DATW], k_first);
                tree_ful[2] = 1'b0;
            end
        end
        check("stall_low_cycles", 64'(lows), 64'd10);
        wait_idle(300);
        check("t2_done", 64'(done), 64'd1);
        check("t2_beat_cnt", 64'(beat_cnt), 64'd50);

        // Corrupted beat 7
        tree_mode = 1;
        do_start(20);
        wait_idle(300);
        check("t3_fail", 64'(fail), 64'd1);
        check("t3_err_code", 64'(err_code), 64'd1);
        check("t3_err_beat", 64'(err_beat), 64'd7);
        check("t3_beat_cnt", 64'(beat_cnt), 64'd8);
        tree_mode = 0;

        // Silent tree: watchdog
        tree_mode = 2;
        do_start(10);
        n = 0;
        while (!fail && n < 100) begin
            tick(1);
            n++;
        end
        check("t4_cycles_to_fail", 64'(n), 64'd16);
        check("t4_err_code", 64'(err_code), 64'd2);
        check("t4_busy", 64'(busy), 64'd0);
        tree_mode = 0;

        // Bad configurations
        do_start(0);
        check("t5_fail", 64'(fail), 64'd1);
        check("t5_err_code", 64'(err_code), 64'd3);
        lows = 0;
        for (int k = 0; k < 5; k++) begin
            if (tree_dinen != '0) lows++;
            tick(1);
        end
        check("t5_no_dinen", 64'(lows), 64'd0);
        do_start(32'h4000_0000);
        check("cfg_limit_err", 64'(err_code), 64'd3);
        do_start(32'h3FFF_FFFF);
        check("cfg_max_busy", 64'(busy), 64'd1);
        check("cfg_max_err", 64'(err_code), 64'd0);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;

        // Reset mid-run, then a clean short run
        do_start(50);
        n = 0;
        while (beat_cnt < 32'd20 && n < 200) begin
            tick(1);
            n++;
        end
        check("t6_reached_20", 64'(beat_cnt), 64'd20);
        rst = 1'b1;
        tick(1);
        check_cleared("midrst");
        rst = 1'b0;
        do_start(10);
        wait_idle(200);
        check("t6_done", 64'(done), 64'd1);
        check("t6_beat_cnt", 64'(beat_cnt), 64'd10);
        check("t6_err_code", 64'(err_code), 64'd0);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got still running, want finished");
        $fatal(1, "bench time limit");
    end

endmodule
